// File: rtl/udp_rx_parser_pkg.sv
// Shared constants and FSM state encoding for the UDP receive parser
// (and the matching TX side).
package udp_rx_parser_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [15:0] ETH_HEAD_LEN  = 16'd14;
  localparam logic [15:0] UDP_HEAD_LEN  = 16'd8;
  // IDLE consumes the first preamble byte, so the SFD lands on PREAMBLE byte index 6.
  localparam logic [15:0] PRE_SFD_IDX   = 16'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_ETH_HEAD,
    S_IP_HEAD,
    S_UDP_HEAD,
    S_RX_DATA,
    S_RX_END
  } rx_state_t;

endpackage

// File: rtl/udp_ip_csum.sv
// Byte-wide 16-bit ones'-complement accumulator with end-around carry.
// o_sum already includes the byte presented this cycle.
module udp_ip_csum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_sum
);

  logic [15:0] r_sum;
  logic        r_hi;
  logic [15:0] w_base;
  logic        w_hi;
  logic [15:0] w_word;
  logic [16:0] w_add;

  // A clear restarts the sum with the current byte as the high half of a word.
  always_comb begin
    w_base = i_clear ? 16'd0 : r_sum;
    w_hi   = i_clear ? 1'b1  : r_hi;
    w_word = w_hi ? {i_byte, 8'h00} : {8'h00, i_byte};
    w_add  = {1'b0, w_base} + {1'b0, w_word};
    o_sum  = i_valid ? (w_add[15:0] + {15'd0, w_add[16]}) : r_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= 16'd0;
      r_hi  <= 1'b1;
    end else if (i_valid) begin
      r_sum <= o_sum;
      r_hi  <= ~w_hi;
    end
  end

endmodule

// File: rtl/udp_rx_parser.sv
// GMII RX parser: Ethernet II / IPv4 / UDP, streams UDP payload bytes.
// Define UDP_RX_IP_CSUM_EN to drop frames whose IPv4 header checksum fails.
module udp_rx_parser
  import udp_rx_parser_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd0, 8'd2}
) (
  input  logic        gmii_rx_clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        rec_en,
  output logic [7:0]  rec_data,
  output logic [15:0] rec_byte_num,
  output logic        rec_pkt_done,
  output logic        rec_pkt_err,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  rx_state_t   r_state, w_state_nxt;
  logic [15:0] r_cnt;
  logic [47:0] r_shift;
  logic [47:0] r_src_mac_stg;
  logic [31:0] r_src_ip_stg;
  logic [3:0]  r_ihl;
  logic [15:0] r_udp_len;
  logic        r_rec_en, r_done, r_err;
  logic [7:0]  r_rec_data;
  logic [15:0] r_byte_num;
  logic [47:0] r_src_mac;
  logic [31:0] r_src_ip;
  logic        w_commit, w_done, w_err, w_data_en, w_csum_ok, w_ip_last;
  logic [15:0] w_ip_len_m1;

  assign w_ip_len_m1 = {10'd0, r_ihl, 2'b00} - 16'd1;
  assign w_ip_last   = (r_cnt == w_ip_len_m1);

`ifdef UDP_RX_IP_CSUM_EN
  logic [15:0] w_csum_sum;
  udp_ip_csum u_ip_csum (
    .clk    (gmii_rx_clk),
    .rst_n  (rst_n),
    .i_clear(r_state == S_IP_HEAD && r_cnt == 16'd0),
    .i_valid(r_state == S_IP_HEAD && gmii_rx_dv),
    .i_byte (gmii_rxd),
    .o_sum  (w_csum_sum)
  );
  assign w_csum_ok = (w_csum_sum == 16'hFFFF);
`else
  assign w_csum_ok = 1'b1;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_data_en   = 1'b0;
    case (r_state)
      S_IDLE:
        if (gmii_rx_dv) w_state_nxt = (gmii_rxd == ETH_PREAMBLE) ? S_PREAMBLE : S_RX_END;
      S_PREAMBLE:
        if (!gmii_rx_dv) w_state_nxt = S_IDLE;
        else if (r_cnt < PRE_SFD_IDX) begin
          if (gmii_rxd != ETH_PREAMBLE) w_state_nxt = S_RX_END;
        end else w_state_nxt = (gmii_rxd == ETH_SFD) ? S_ETH_HEAD : S_RX_END;
      S_ETH_HEAD:
        if (!gmii_rx_dv) w_state_nxt = S_IDLE;
        else if (r_cnt == 16'd6 && r_shift != BOARD_MAC && r_shift != '1) w_state_nxt = S_RX_END;
        else if (r_cnt == ETH_HEAD_LEN - 16'd1)
          w_state_nxt = ({r_shift[7:0], gmii_rxd} == ETH_TYPE_IPV4) ? S_IP_HEAD : S_RX_END;
      S_IP_HEAD:
        if (!gmii_rx_dv) w_state_nxt = S_IDLE;
        else if ((r_cnt == 16'd0 && (gmii_rxd[7:4] != 4'd4 || gmii_rxd[3:0] < 4'd5)) ||
                 (r_cnt == 16'd9 && gmii_rxd != IP_PROTO_UDP) ||
                 (r_cnt == 16'd19 && {r_shift[23:0], gmii_rxd} != BOARD_IP))
          w_state_nxt = S_RX_END;
        else if (r_cnt != 16'd0 && w_ip_last) w_state_nxt = w_csum_ok ? S_UDP_HEAD : S_RX_END;
      S_UDP_HEAD:
        if (!gmii_rx_dv) w_state_nxt = S_IDLE;
        else if (r_cnt == UDP_HEAD_LEN - 16'd1) begin
          if (r_udp_len < UDP_HEAD_LEN) begin
            w_err       = 1'b1;
            w_state_nxt = S_RX_END;
          end else begin
            w_commit = 1'b1;
            if (r_udp_len == UDP_HEAD_LEN) begin
              w_done      = 1'b1;
              w_state_nxt = S_RX_END;
            end else w_state_nxt = S_RX_DATA;
          end
        end
      S_RX_DATA:
        if (!gmii_rx_dv) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_data_en = 1'b1;
          if (r_cnt == r_byte_num - 16'd1) begin
            w_done      = 1'b1;
            w_state_nxt = S_RX_END;
          end
        end
      S_RX_END:
        if (!gmii_rx_dv) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 16'd0;
      r_shift       <= 48'd0;
      r_src_mac_stg <= 48'd0;
      r_src_ip_stg  <= 32'd0;
      r_ihl         <= 4'd5;
      r_udp_len     <= 16'd0;
      r_rec_en      <= 1'b0;
      r_rec_data    <= 8'd0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_byte_num    <= 16'd0;
      r_src_mac     <= 48'd0;
      r_src_ip      <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state  <= w_state_nxt;
      r_rec_en <= w_data_en;
      r_done   <= w_done;
      r_err    <= w_err;
      if (w_state_nxt != r_state) r_cnt <= 16'd0;
      else if (gmii_rx_dv)        r_cnt <= r_cnt + 16'd1;
      if (gmii_rx_dv) r_shift <= {r_shift[39:0], gmii_rxd};
      if (w_data_en)  r_rec_data <= gmii_rxd;
      // Sender fields are staged while the header streams past and only published on acceptance.
      if (r_state == S_ETH_HEAD && gmii_rx_dv && r_cnt == 16'd12) r_src_mac_stg <= r_shift;
      if (r_state == S_IP_HEAD  && gmii_rx_dv && r_cnt == 16'd16) r_src_ip_stg  <= r_shift[31:0];
      if (r_state == S_IP_HEAD  && gmii_rx_dv && r_cnt == 16'd0)  r_ihl <= gmii_rxd[3:0];
      if (r_state == S_UDP_HEAD && gmii_rx_dv && r_cnt == 16'd5)
        r_udp_len <= {r_shift[7:0], gmii_rxd};
      if (w_commit) begin
        r_byte_num <= r_udp_len - UDP_HEAD_LEN;
        r_src_mac  <= r_src_mac_stg;
        r_src_ip   <= r_src_ip_stg;
      end
    end
  end

  assign rec_en       = r_rec_en;
  assign rec_data     = r_rec_data;
  assign rec_byte_num = r_byte_num;
  assign rec_pkt_done = r_done;
  assign rec_pkt_err  = r_err;
  assign src_mac      = r_src_mac;
  assign src_ip       = r_src_ip;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed self-checking bench for udp_rx_parser: builds GMII frames byte by byte
// and checks payload stream, length, done/err pulses and captured sender.
module tb_udp_rx_parser;

  localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
  localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] BOARD_IP  = 32'hC0_A8_00_02;
  localparam logic [31:0] OTHER_IP  = 32'hC0_A8_00_03;
  localparam logic [47:0] SRC_MAC   = 48'hA0_B1_C2_D3_E4_F5;
  localparam logic [31:0] SRC_IP    = 32'hC0_A8_00_0A;
  localparam logic [47:0] SRC2_MAC  = 48'h02_00_00_00_00_99;
  localparam logic [31:0] SRC2_IP   = 32'hC0_A8_00_63;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  rxd = 8'd0;
  logic        rec_en, rec_pkt_done, rec_pkt_err;
  logic [7:0]  rec_data;
  logic [15:0] rec_byte_num;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  logic [7:0] frm[$];
  logic [7:0] got[$];
  int n_done, n_err, done_at;
  int n_cmp = 0;
  int n_bad = 0;

  udp_rx_parser #(.BOARD_MAC(BOARD_MAC), .BOARD_IP(BOARD_IP)) dut (
    .gmii_rx_clk (clk),
    .rst_n       (rst_n),
    .gmii_rx_dv  (dv),
    .gmii_rxd    (rxd),
    .rec_en      (rec_en),
    .rec_data    (rec_data),
    .rec_byte_num(rec_byte_num),
    .rec_pkt_done(rec_pkt_done),
    .rec_pkt_err (rec_pkt_err),
    .src_mac     (src_mac),
    .src_ip      (src_ip)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (rec_en) got.push_back(rec_data);
    if (rec_pkt_done) begin
      n_done++;
      done_at = got.size();
    end
    if (rec_pkt_err) n_err++;
  end

  function automatic logic [15:0] ip_csum(input int start, input int len);
    int s = 0;
    for (int i = 0; i < len; i += 2) s += {frm[start+i], frm[start+i+1]};
    s = (s & 32'hFFFF) + (s >> 16);
    s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  task automatic build_frame(input logic [47:0] dmac, input logic [47:0] smac,
                             input logic [15:0] etype, input logic [31:0] dip,
                             input logic [31:0] sip, input int ihl, input int plen,
                             input int udp_len, input logic [7:0] pstart,
                             input logic [7:0] pstep, input int pad,
                             input logic [15:0] csum_delta);
    logic [15:0] tl, ul, cs;
    tl = 16'(ihl*4 + 8 + plen);
    ul = 16'(udp_len);
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) frm.push_back(dmac[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(smac[i*8 +: 8]);
    frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
    frm.push_back({4'd4, 4'(ihl)}); frm.push_back(8'h00);
    frm.push_back(tl[15:8]); frm.push_back(tl[7:0]);
    frm.push_back(8'h12); frm.push_back(8'h34); frm.push_back(8'h40); frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(8'h11); frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 3; i >= 0; i--) frm.push_back(sip[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) frm.push_back(dip[i*8 +: 8]);
    for (int i = 0; i < (ihl - 5) * 4; i++) frm.push_back(8'h00);
    cs = ip_csum(22, ihl*4) + csum_delta;
    frm[32] = cs[15:8];
    frm[33] = cs[7:0];
    frm.push_back(8'h04); frm.push_back(8'hD2); frm.push_back(8'h16); frm.push_back(8'h2E);
    frm.push_back(ul[15:8]); frm.push_back(ul[7:0]); frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 0; i < plen; i++) frm.push_back(8'(pstart + 8'(i) * pstep));
    repeat (pad) frm.push_back(8'h00);
    frm.push_back(8'hDE); frm.push_back(8'hAD); frm.push_back(8'hBE); frm.push_back(8'hEF);
  endtask

  task automatic send_frame(input int gap);
    foreach (frm[i]) begin
      @(posedge clk); #1;
      dv  = 1'b1;
      rxd = frm[i];
    end
    @(posedge clk); #1;
    dv  = 1'b0;
    rxd = 8'd0;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got.delete();
    n_done  = 0;
    n_err   = 0;
    done_at = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_cmp++; if (rec_en !== 1'b0)        begin n_bad++; $display("FAIL reset_rec_en got %b want 0", rec_en); end
    n_cmp++; if (rec_data !== 8'd0)      begin n_bad++; $display("FAIL reset_rec_data got %h want 00", rec_data); end
    n_cmp++; if (rec_byte_num !== 16'd0) begin n_bad++; $display("FAIL reset_byte_num got %0d want 0", rec_byte_num); end
    n_cmp++; if (rec_pkt_done !== 1'b0 || rec_pkt_err !== 1'b0)
      begin n_bad++; $display("FAIL reset_done_err got %b%b want 00", rec_pkt_done, rec_pkt_err); end
    n_cmp++; if (src_mac !== 48'd0 || src_ip !== 32'd0)
      begin n_bad++; $display("FAIL reset_src got %h/%h want 0/0", src_mac, src_ip); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_valid_frame();
    clear_mon();
    build_frame(BOARD_MAC, SRC_MAC, 16'h0800, BOARD_IP, SRC_IP, 5, 10, 18, 8'h11, 8'h11, 0, 16'h0);
    send_frame(4); idle(2);
    n_cmp++; if (got.size() != 10) begin n_bad++; $display("FAIL valid_count got %0d want 10", got.size()); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (got.size() <= i || got[i] !== 8'(8'h11 * (i + 1)))
        begin n_bad++; $display("FAIL valid_data[%0d] want %h", i, 8'(8'h11 * (i + 1))); end
    end
    n_cmp++; if (rec_byte_num !== 16'd10) begin n_bad++; $display("FAIL valid_byte_num got %0d want 10", rec_byte_num); end
    n_cmp++; if (n_done != 1 || done_at != 10) begin n_bad++; $display("FAIL valid_done got %0d at %0d want 1 at 10", n_done, done_at); end
    n_cmp++; if (n_err != 0) begin n_bad++; $display("FAIL valid_err got %0d want 0", n_err); end
    n_cmp++; if (src_mac !== SRC_MAC) begin n_bad++; $display("FAIL valid_src_mac got %h want %h", src_mac, SRC_MAC); end
    n_cmp++; if (src_ip !== SRC_IP) begin n_bad++; $display("FAIL valid_src_ip got %h want %h", src_ip, SRC_IP); end
  endtask

  task automatic test_reject();
    clear_mon();
    build_frame(BOARD_MAC, SRC2_MAC, 16'h0800, OTHER_IP, SRC2_IP, 5, 10, 18, 8'h11, 8'h11, 0, 16'h0);
    send_frame(4);
    build_frame(BOARD_MAC, SRC2_MAC, 16'h0806, BOARD_IP, SRC2_IP, 5, 10, 18, 8'h11, 8'h11, 0, 16'h0);
    send_frame(4); idle(2);
    n_cmp++; if (got.size() != 0 || n_done != 0 || n_err != 0)
      begin n_bad++; $display("FAIL reject_activity got en=%0d done=%0d err=%0d want 0/0/0", got.size(), n_done, n_err); end
    n_cmp++; if (rec_byte_num !== 16'd10) begin n_bad++; $display("FAIL reject_byte_num got %0d want 10", rec_byte_num); end
    n_cmp++; if (src_mac !== SRC_MAC || src_ip !== SRC_IP)
      begin n_bad++; $display("FAIL reject_src got %h/%h want %h/%h", src_mac, src_ip, SRC_MAC, SRC_IP); end
  endtask

  task automatic test_broadcast_padding();
    clear_mon();
    build_frame(BCAST_MAC, SRC_MAC, 16'h0800, BOARD_IP, SRC_IP, 5, 30, 38, 8'h30, 8'h01, 8, 16'h0);
    send_frame(4); idle(2);
    n_cmp++; if (got.size() != 30) begin n_bad++; $display("FAIL bcast_count got %0d want 30", got.size()); end
    for (int i = 0; i < 30; i++) begin
      n_cmp++;
      if (got.size() <= i || got[i] !== 8'(8'h30 + i)) begin n_bad++; $display("FAIL bcast_data[%0d] want %h", i, 8'(8'h30 + i)); end
    end
    n_cmp++; if (n_done != 1 || done_at != 30) begin n_bad++; $display("FAIL bcast_done got %0d at %0d want 1 at 30", n_done, done_at); end
    n_cmp++; if (rec_byte_num !== 16'd30 || n_err != 0)
      begin n_bad++; $display("FAIL bcast_len_err got %0d/%0d want 30/0", rec_byte_num, n_err); end
  endtask

  task automatic test_truncated();
    clear_mon();
    build_frame(BOARD_MAC, SRC_MAC, 16'h0800, BOARD_IP, SRC_IP, 5, 30, 38, 8'h40, 8'h01, 0, 16'h0);
    while (frm.size() > 55) void'(frm.pop_back());
    send_frame(4); idle(2);
    n_cmp++; if (got.size() != 5) begin n_bad++; $display("FAIL trunc_count got %0d want 5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (got.size() <= i || got[i] !== 8'(8'h40 + i)) begin n_bad++; $display("FAIL trunc_data[%0d] want %h", i, 8'(8'h40 + i)); end
    end
    n_cmp++; if (n_err != 1 || n_done != 0) begin n_bad++; $display("FAIL trunc_err_done got %0d/%0d want 1/0", n_err, n_done); end
    n_cmp++; if (rec_byte_num !== 16'd30) begin n_bad++; $display("FAIL trunc_byte_num got %0d want 30", rec_byte_num); end
    clear_mon();
    build_frame(BOARD_MAC, SRC_MAC, 16'h0800, BOARD_IP, SRC_IP, 5, 4, 12, 8'h70, 8'h01, 0, 16'h0);
    send_frame(4); idle(2);
    n_cmp++; if (got.size() != 4 || n_done != 1 || n_err != 0)
      begin n_bad++; $display("FAIL trunc_next got en=%0d done=%0d err=%0d want 4/1/0", got.size(), n_done, n_err); end
    n_cmp++; if (rec_byte_num !== 16'd4) begin n_bad++; $display("FAIL trunc_next_len got %0d want 4", rec_byte_num); end
  endtask

  task automatic test_zero_len();
    clear_mon();
    build_frame(BOARD_MAC, SRC_MAC, 16'h0800, BOARD_IP, SRC_IP, 5, 0, 8, 8'h00, 8'h00, 0, 16'h0);
    send_frame(4); idle(2);
    n_cmp++; if (rec_byte_num !== 16'd0) begin n_bad++; $display("FAIL zero_byte_num got %0d want 0", rec_byte_num); end
    n_cmp++; if (got.size() != 0 || n_done != 1 || done_at != 0 || n_err != 0)
      begin n_bad++; $display("FAIL zero_pulses got en=%0d done=%0d err=%0d want 0/1/0", got.size(), n_done, n_err); end
    clear_mon();
    build_frame(BOARD_MAC, SRC_MAC, 16'h0800, BOARD_IP, SRC_IP, 5, 0, 6, 8'h00, 8'h00, 0, 16'h0);
    send_frame(4); idle(2);
    n_cmp++; if (got.size() != 0 || n_done != 0 || n_err != 1)
      begin n_bad++; $display("FAIL short_udp got en=%0d done=%0d err=%0d want 0/0/1", got.size(), n_done, n_err); end
  endtask

  task automatic test_csum();
    clear_mon();
    build_frame(BOARD_MAC, SRC2_MAC, 16'h0800, BOARD_IP, SRC2_IP, 5, 10, 18, 8'h01, 8'h03, 0, 16'h0001);
    send_frame(4); idle(2);
`ifdef UDP_RX_IP_CSUM_EN
    n_cmp++; if (got.size() != 0 || n_done != 0 || n_err != 0)
      begin n_bad++; $display("FAIL csum_drop got en=%0d done=%0d err=%0d want 0/0/0", got.size(), n_done, n_err); end
    n_cmp++; if (src_ip !== SRC_IP) begin n_bad++; $display("FAIL csum_src_ip got %h want %h", src_ip, SRC_IP); end
`else
    n_cmp++; if (got.size() != 10 || n_done != 1 || n_err != 0)
      begin n_bad++; $display("FAIL csum_ignore got en=%0d done=%0d err=%0d want 10/1/0", got.size(), n_done, n_err); end
    n_cmp++; if (src_ip !== SRC2_IP) begin n_bad++; $display("FAIL csum_src_ip got %h want %h", src_ip, SRC2_IP); end
`endif
  endtask

  task automatic test_reset_mid();
    build_frame(BOARD_MAC, SRC2_MAC, 16'h0800, BOARD_IP, SRC2_IP, 5, 30, 38, 8'h01, 8'h01, 0, 16'h0);
    for (int i = 0; i < frm.size(); i++) begin
      @(posedge clk); #1;
      if (i == 55) rst_n = 1'b0;
      if (i == 57) begin
        n_cmp++; if (rec_en !== 1'b0 || rec_pkt_done !== 1'b0 || rec_pkt_err !== 1'b0)
          begin n_bad++; $display("FAIL midrst_pulses got %b%b%b want 000", rec_en, rec_pkt_done, rec_pkt_err); end
        n_cmp++; if (rec_byte_num !== 16'd0 || src_mac !== 48'd0 || src_ip !== 32'd0)
          begin n_bad++; $display("FAIL midrst_state got %0d/%h/%h want 0/0/0", rec_byte_num, src_mac, src_ip); end
        rst_n = 1'b1;
        clear_mon();
      end
      dv  = 1'b1;
      rxd = frm[i];
    end
    @(posedge clk); #1;
    dv = 1'b0;
    idle(3);
    n_cmp++; if (got.size() != 0 || n_done != 0 || n_err != 0)
      begin n_bad++; $display("FAIL midrst_tail got en=%0d done=%0d err=%0d want 0/0/0", got.size(), n_done, n_err); end
    clear_mon();
    build_frame(BOARD_MAC, SRC_MAC, 16'h0800, BOARD_IP, SRC_IP, 5, 6, 14, 8'h90, 8'h01, 0, 16'h0);
    send_frame(4); idle(2);
    n_cmp++; if (got.size() != 6 || n_done != 1 || n_err != 0 || rec_byte_num !== 16'd6)
      begin n_bad++; $display("FAIL midrst_next got en=%0d done=%0d err=%0d len=%0d want 6/1/0/6", got.size(), n_done, n_err, rec_byte_num); end
    n_cmp++; if (src_mac !== SRC_MAC || src_ip !== SRC_IP)
      begin n_bad++; $display("FAIL midrst_src got %h/%h want %h/%h", src_mac, src_ip, SRC_MAC, SRC_IP); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b;
    clear_mon();
    build_frame(BOARD_MAC, SRC_MAC, 16'h0800, BOARD_IP, SRC_IP, 5, 8, 16, 8'hA0, 8'h01, 0, 16'h0);
    send_frame(1);
    build_frame(BOARD_MAC, SRC2_MAC, 16'h0800, BOARD_IP, SRC2_IP, 6, 12, 20, 8'hC0, 8'h02, 0, 16'h0);
    send_frame(4); idle(2);
    n_cmp++; if (got.size() != 20 || n_done != 2 || n_err != 0)
      begin n_bad++; $display("FAIL b2b_pulses got en=%0d done=%0d err=%0d want 20/2/0", got.size(), n_done, n_err); end
    for (int i = 0; i < 20; i++) begin
      exp_b = (i < 8) ? 8'(8'hA0 + i) : 8'(8'hC0 + 2 * (i - 8));
      n_cmp++;
      if (got.size() <= i || got[i] !== exp_b) begin n_bad++; $display("FAIL b2b_data[%0d] want %h", i, exp_b); end
    end
    n_cmp++; if (rec_byte_num !== 16'd12 || src_ip !== SRC2_IP || src_mac !== SRC2_MAC)
      begin n_bad++; $display("FAIL b2b_last got %0d/%h/%h want 12/%h/%h", rec_byte_num, src_ip, src_mac, SRC2_IP, SRC2_MAC); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_valid_frame();
    test_reject();
    test_broadcast_padding();
    test_truncated();
    test_zero_len();
    test_csum();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
